// File: rtl/parking_gate_arbiter.sv
// Two-gate entry / single exit barrier arbiter with round-robin entry selection and timed barrier hold.
// Optional grant/deny statistics counters are enabled by defining PARK_GATE_STATS_EN.
module parking_gate_arbiter #(
   parameter int unsigned BARRIER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ent_req,
   input  logic [1:0] ent_uni,
   output logic [1:0] ent_gnt,
   output logic [1:0] ent_deny,
   input  logic       ext_req,
   input  logic       ext_uni,
   output logic       ext_gnt,
   input  logic       uni_is_vacated_space,
   input  logic       is_vacated_space,
   output logic       car_entered,
   output logic       is_uni_car_entered,
   output logic       car_exited,
   output logic       is_uni_car_exited,
   output logic       busy,
   output logic       barrier_open
`ifdef PARK_GATE_STATS_EN
   ,
   output logic [7:0] grant_cnt,
   output logic [7:0] deny_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, EXIT, ENTER, DENY, HOLD} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(BARRIER_CYCLES);

   state_t     state_q, state_d;
   logic       gate_q, gate_d;
   logic       cls_q, cls_d;
   logic       rr_q, rr_d;
   logic [3:0] timer_q, timer_d;

   logic       sel_gate;
   logic       sel_uni;

   logic [1:0] ent_gnt_d, ent_deny_d;
   logic       ext_gnt_d, car_entered_d, is_uni_car_entered_d;
   logic       car_exited_d, is_uni_car_exited_d, busy_d, barrier_open_d;

   // State, latched request context and all outputs are registered together,
   // so outputs always reflect the state being entered at this edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q            <= IDLE;
         gate_q             <= 1'b0;
         cls_q              <= 1'b0;
         rr_q               <= 1'b0;
         timer_q            <= 4'd0;
         ent_gnt            <= 2'b00;
         ent_deny           <= 2'b00;
         ext_gnt            <= 1'b0;
         car_entered        <= 1'b0;
         is_uni_car_entered <= 1'b0;
         car_exited         <= 1'b0;
         is_uni_car_exited  <= 1'b0;
         busy               <= 1'b0;
         barrier_open       <= 1'b0;
      end else begin
         state_q            <= state_d;
         gate_q             <= gate_d;
         cls_q              <= cls_d;
         rr_q               <= rr_d;
         timer_q            <= timer_d;
         ent_gnt            <= ent_gnt_d;
         ent_deny           <= ent_deny_d;
         ext_gnt            <= ext_gnt_d;
         car_entered        <= car_entered_d;
         is_uni_car_entered <= is_uni_car_entered_d;
         car_exited         <= car_exited_d;
         is_uni_car_exited  <= is_uni_car_exited_d;
         busy               <= busy_d;
         barrier_open       <= barrier_open_d;
      end
   end

   // Requests are only looked at in IDLE; exit beats entry, and a double entry
   // request is resolved by the round-robin pointer.
   always_comb begin
      state_d  = state_q;
      gate_d   = gate_q;
      cls_d    = cls_q;
      rr_d     = rr_q;
      timer_d  = timer_q;
      sel_gate = (ent_req == 2'b11) ? rr_q : ent_req[1];
      sel_uni  = ent_uni[sel_gate];
      case (state_q)
         IDLE: begin
            if (ext_req) begin
               state_d = EXIT;
               cls_d   = ext_uni;
            end else if (ent_req != 2'b00) begin
               state_d = (sel_uni ? uni_is_vacated_space : is_vacated_space) ? ENTER : DENY;
               gate_d  = sel_gate;
               cls_d   = sel_uni;
               rr_d    = ~sel_gate;
            end
         end
         EXIT, ENTER: begin
            state_d = HOLD;
            timer_d = HOLD_LOAD;
         end
         DENY: state_d = IDLE;
         HOLD: begin
            if (timer_q <= 4'd1) begin
               state_d = IDLE;
               timer_d = 4'd0;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ent_gnt_d            = 2'b00;
      ent_deny_d           = 2'b00;
      ext_gnt_d            = 1'b0;
      car_entered_d        = 1'b0;
      is_uni_car_entered_d = 1'b0;
      car_exited_d         = 1'b0;
      is_uni_car_exited_d  = 1'b0;
      busy_d               = (state_d != IDLE);
      barrier_open_d       = (state_d == HOLD);
      case (state_d)
         EXIT: begin
            ext_gnt_d           = 1'b1;
            car_exited_d        = 1'b1;
            is_uni_car_exited_d = cls_d;
         end
         ENTER: begin
            ent_gnt_d[gate_d]    = 1'b1;
            car_entered_d        = 1'b1;
            is_uni_car_entered_d = cls_d;
         end
         DENY: ent_deny_d[gate_d] = 1'b1;
         default: ;
      endcase
   end

`ifdef PARK_GATE_STATS_EN
   // Saturating event counters; each grant/deny state lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant_cnt <= 8'd0;
         deny_cnt  <= 8'd0;
      end else begin
         if ((state_q == ENTER || state_q == EXIT) && grant_cnt != 8'hFF)
            grant_cnt <= grant_cnt + 8'd1;
         if (state_q == DENY && deny_cnt != 8'hFF)
            deny_cnt <= deny_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter (default BARRIER_CYCLES = 4).
// Statistics checks are compiled in when PARK_GATE_STATS_EN is defined.
module tb_parking_gate_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] ent_req, ent_uni, ent_gnt, ent_deny;
   logic       ext_req, ext_uni, ext_gnt;
   logic       uni_is_vacated_space, is_vacated_space;
   logic       car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
   logic       busy, barrier_open;
`ifdef PARK_GATE_STATS_EN
   logic [7:0] grant_cnt, deny_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [11:0] all_out;
   assign all_out = {ent_gnt, ent_deny, ext_gnt, car_entered, is_uni_car_entered,
                     car_exited, is_uni_car_exited, busy, barrier_open, 1'b0};

   parking_gate_arbiter #(.BARRIER_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .ent_req(ent_req), .ent_uni(ent_uni), .ent_gnt(ent_gnt), .ent_deny(ent_deny),
      .ext_req(ext_req), .ext_uni(ext_uni), .ext_gnt(ext_gnt),
      .uni_is_vacated_space(uni_is_vacated_space), .is_vacated_space(is_vacated_space),
      .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
      .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
      .busy(busy), .barrier_open(barrier_open)
`ifdef PARK_GATE_STATS_EN
      , .grant_cnt(grant_cnt), .deny_cnt(deny_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ent_req = 2'b00; ent_uni = 2'b00; ext_req = 1'b0; ext_uni = 1'b0;
      uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
      step();
      step();
      n_cmp++;
      if (all_out !== 12'h000) begin
         n_err++;
         $display("[TB] FAIL reset_outputs: got %h want %h", all_out, 12'h000);
      end
      rst = 1'b1;
   endtask

   task automatic test_exit();
      bit to;
      ext_req = 1'b1; ext_uni = 1'b1;
      step();
      ext_req = 1'b0; ext_uni = 1'b0;
      n_cmp++;
      // ext_gnt, car_exited, is_uni_car_exited, busy
      if (all_out !== 12'b00_00_1_0_0_1_1_1_0_0) begin
         n_err++;
         $display("[TB] FAIL exit_pulse: got %b want %b", all_out, 12'b00_00_1_0_0_1_1_1_0_0);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (all_out !== 12'b00_00_0_0_0_0_0_1_1_0) begin
            n_err++;
            $display("[TB] FAIL exit_hold%0d: got %b want %b", i, all_out, 12'b00_00_0_0_0_0_0_1_1_0);
         end
      end
      step();
      n_cmp++;
      if (all_out !== 12'h000) begin
         n_err++;
         $display("[TB] FAIL exit_back_idle: got %b want %b", all_out, 12'h000);
      end
      wait_idle(to);
   endtask

   task automatic test_round_robin();
      bit to;
      logic [1:0] want [3];
      want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01;
      for (int i = 0; i < 3; i++) begin
         ent_req = 2'b11; ent_uni = 2'b00;
         step();
         ent_req = 2'b00;
         n_cmp++;
         if (ent_gnt !== want[i] || car_entered !== 1'b1 || is_uni_car_entered !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rr_grant%0d: got gnt=%b ce=%b uni=%b want gnt=%b ce=1 uni=0",
                     i, ent_gnt, car_entered, is_uni_car_entered, want[i]);
         end
         wait_idle(to);
         n_cmp++;
         if (to !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rr_timeout%0d: got timeout=%b want 0", i, to);
         end
      end
   endtask

   task automatic test_exit_priority();
      bit to;
      ent_req = 2'b01; ent_uni = 2'b00; ext_req = 1'b1; ext_uni = 1'b0;
      step();
      ext_req = 1'b0;
      n_cmp++;
      if (ext_gnt !== 1'b1 || ent_gnt !== 2'b00 || is_uni_car_exited !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL prio_exit: got ext=%b ent=%b uni=%b want ext=1 ent=00 uni=0",
                  ext_gnt, ent_gnt, is_uni_car_exited);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++;
         if (ent_gnt !== 2'b00 || barrier_open !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL prio_ignored%0d: got gnt=%b bo=%b want gnt=00 bo=1", i, ent_gnt, barrier_open);
         end
      end
      step();
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL prio_idle: got busy=%b want 0", busy);
      end
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (ent_gnt !== 2'b01 || car_entered !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL prio_entry_after: got gnt=%b ce=%b want gnt=01 ce=1", ent_gnt, car_entered);
      end
      wait_idle(to);
   endtask

   task automatic test_deny();
      bit to;
      // rr is 1 here after gate 0 was last granted; deny of gate 0 keeps it at 1
      ent_req = 2'b01; ent_uni = 2'b01; uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (all_out !== 12'b00_01_0_0_0_0_0_1_0_0) begin
         n_err++;
         $display("[TB] FAIL deny_pulse: got %b want %b", all_out, 12'b00_01_0_0_0_0_0_1_0_0);
      end
      step();
      n_cmp++;
      if (all_out !== 12'h000) begin
         n_err++;
         $display("[TB] FAIL deny_no_barrier: got %b want %b", all_out, 12'h000);
      end
      ent_req = 2'b11; ent_uni = 2'b00; uni_is_vacated_space = 1'b1;
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (ent_gnt !== 2'b10) begin
         n_err++;
         $display("[TB] FAIL deny_rr: got gnt=%b want 10", ent_gnt);
      end
      wait_idle(to);
   endtask

   task automatic test_class();
      bit to;
      ent_req = 2'b10; ent_uni = 2'b10; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (ent_gnt !== 2'b10 || is_uni_car_entered !== 1'b1 || car_entered !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL class_uni_grant: got gnt=%b ce=%b uni=%b want 10 1 1",
                  ent_gnt, car_entered, is_uni_car_entered);
      end
      wait_idle(to);
      ent_req = 2'b10; ent_uni = 2'b00; uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (ent_deny !== 2'b10 || car_entered !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL class_std_deny: got deny=%b ce=%b want 10 0", ent_deny, car_entered);
      end
      is_vacated_space = 1'b1;
      wait_idle(to);
   endtask

   task automatic test_reset_mid_hold();
      ent_req = 2'b01; ent_uni = 2'b00;
      step();
      ent_req = 2'b00;
      step();
      step();
      rst = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== 12'h000) begin
         n_err++;
         $display("[TB] FAIL rst_mid_hold: got %b want %b", all_out, 12'h000);
      end
      step();
      rst = 1'b1;
      ent_req = 2'b10;
      step();
      ent_req = 2'b00;
      n_cmp++;
      if (ent_gnt !== 2'b10 || car_entered !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL rst_first_req: got gnt=%b ce=%b want 10 1", ent_gnt, car_entered);
      end
   endtask

`ifdef PARK_GATE_STATS_EN
   task automatic test_stats();
      bit to;
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ent_req = 2'b01; ent_uni = 2'b00;
         step();
         ent_req = 2'b00;
         wait_idle(to);
      end
      n_cmp++;
      if (grant_cnt !== 8'd255 || deny_cnt !== 8'd0) begin
         n_err++;
         $display("[TB] FAIL stats_sat: got g=%0d d=%0d want 255 0", grant_cnt, deny_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exit();
      test_round_robin();
      test_exit_priority();
      test_deny();
      test_class();
      test_reset_mid_hold();
`ifdef PARK_GATE_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/parking_gate_arbiter.md
PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 SHALL have parameter BARRIER_CYCLES, default 4, range 1..15: number of cycles the barrier stays open after each grant.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port ent_req, input, 2: level entry request, one bit per entry gate (gate 0, gate 1).
REQ-005 SHALL have port ent_uni, input, 2: per-gate class of the requesting car (1 = uni car).
REQ-006 SHALL have port ent_gnt, output, 2: one-cycle entry grant pulse per gate.
REQ-007 SHALL have port ent_deny, output, 2: one-cycle deny pulse per gate when no space of the requested class exists.
REQ-008 SHALL have ports ext_req and ext_uni, input, 1 each: level exit request and class of the exiting car.
REQ-009 SHALL have port ext_gnt, output, 1: one-cycle exit grant pulse.
REQ-010 SHALL have ports uni_is_vacated_space and is_vacated_space, input, 1 each: space-available flags from the parking core.
REQ-011 SHALL have ports car_entered, is_uni_car_entered, car_exited and is_uni_car_exited, output, 1 each: event strobes to the parking core.
REQ-012 SHALL have ports busy and barrier_open, output, 1 each: busy is high whenever state is not IDLE; barrier_open is high in HOLD.

Function
REQ-013 SHALL implement the FSM states IDLE, EXIT, ENTER, DENY and HOLD, with all outputs registered.
REQ-014 SHALL sample requests only in IDLE; requests in any other state SHALL be ignored and not queued.
REQ-015 In IDLE, ext_req=1 SHALL win over any entry request: next state EXIT, with ext_uni latched.
REQ-016 In IDLE with no exit request, the entry gate SHALL be selected as follows: if only one gate requests, that gate; if both request, the gate indicated by the 1-bit round-robin pointer rr.
REQ-017 For the selected gate g, the arbiter SHALL go to ENTER if the class flag (uni_is_vacated_space when ent_uni[g]=1, else is_vacated_space) is 1 at the decision edge; otherwise it SHALL go to DENY. In both cases g and its class SHALL be latched.
REQ-018 After any entry grant or deny to gate g, rr SHALL become ~g; an exit grant SHALL leave rr unchanged.
REQ-019 EXIT SHALL last one cycle with car_exited=1, is_uni_car_exited=latched class and ext_gnt=1, then go to HOLD.
REQ-020 ENTER SHALL last one cycle with car_entered=1, is_uni_car_entered=latched class and ent_gnt[g]=1, then go to HOLD.
REQ-021 DENY SHALL last one cycle with ent_deny[g]=1 and no core strobe, then return to IDLE; the barrier SHALL NOT open.
REQ-022 HOLD SHALL load a 4-bit timer with BARRIER_CYCLES on entry, last exactly BARRIER_CYCLES cycles, then return to IDLE.
REQ-023 Latency: a request sampled at edge k SHALL produce its grant or deny pulse in cycle k+1; after a grant, the next request SHALL be sampled no earlier than edge k+2+BARRIER_CYCLES.
REQ-024 Requesters SHALL drop their request in the grant or deny cycle; a request still high on return to IDLE SHALL be treated as a new request.
REQ-025 is_uni_car_* outputs SHALL be 0 whenever their matching strobe is 0.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, rr=0, timer=0, latched gate and class to 0, and every output to 0, including mid-HOLD or mid-strobe.
REQ-027 After rst is released, the first request SHALL be sampled at the first rising edge.

Configuration
REQ-028 With macro PARK_GATE_STATS_EN defined, the block SHALL add outputs grant_cnt[7:0] and deny_cnt[7:0], reset to 0 and saturating at 255, incrementing in ENTER/EXIT and DENY respectively.
REQ-029 With PARK_GATE_STATS_EN undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then ext_req=1, ext_uni=1 for one sample -> next cycle car_exited=1, is_uni_car_exited=1, ext_gnt=1; barrier_open high exactly 4 cycles; busy low afterwards.
REQ-031 ent_req=2'b11 in consecutive IDLE windows, spaces available -> grants go to gate 0, then 1, then 0 (rr alternates).
REQ-032 ent_req=2'b01, ext_req=1 same edge -> exit granted first; gate 0 is granted in the first IDLE after HOLD, provided its request is still high.
REQ-033 ent_uni[0]=1, uni_is_vacated_space=0, is_vacated_space=1 -> ent_deny[0]=1 for one cycle, no car_entered, barrier_open stays 0, rr=1.
REQ-034 rst asserted in the 2nd HOLD cycle -> all outputs 0 immediately; after release, a new ent_req[1] is granted with latency 1.
REQ-035 With PARK_GATE_STATS_EN defined, 300 granted entries -> grant_cnt=255 (saturated), deny_cnt=0.
